// File: rtl/rv32_decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// Opcodes, ALU control codes and the decoded-entry bundle.
package rv32_decode_pkg;

  localparam int IMM_W = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       alu_ctrl;
    logic             w_en;
    logic [IMM_W-1:0] imm;
    logic             illegal;
    logic             muldiv;
  } dec_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I instruction decoder.
// RV32M decode is enabled by defining DECODE_RV32M_EN.
module rv32_decode_comb
  import rv32_decode_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign op = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};

  logic wr;
  logic ill;

  // Field extraction per opcode, then legality and write-enable gating
  always_comb begin
    dec_o = '0;
    wr    = 1'b0;
    ill   = 1'b0;
    case (op)
      OP: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.rd       = inst_i[11:7];
        dec_o.alu_ctrl = {f7[5], f3};
        wr             = 1'b1;
        if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          dec_o.muldiv   = 1'b1;
          dec_o.alu_ctrl = {1'b0, f3};
`else
          ill = 1'b1;
`endif
        end else if (f7 == 7'b0100000) begin
          ill = !((f3 == 3'b000) || (f3 == 3'b101));
        end else if (f7 != 7'b0) begin
          ill = 1'b1;
        end
      end
      OP_IMM: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rd       = inst_i[11:7];
        dec_o.imm      = imm_i;
        dec_o.alu_ctrl = {1'b0, f3};
        wr             = 1'b1;
        if (f3 == 3'b001) begin
          ill = (f7 != 7'b0);
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000) dec_o.alu_ctrl = ALU_SRA;
          else if (f7 != 7'b0)  ill = 1'b1;
        end
      end
      LOAD: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rd       = inst_i[11:7];
        dec_o.imm      = imm_i;
        dec_o.alu_ctrl = ALU_ADD;
        wr             = 1'b1;
      end
      STORE: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.imm      = imm_s;
        dec_o.alu_ctrl = ALU_ADD;
      end
      BRANCH: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.imm      = imm_b;
        dec_o.alu_ctrl = ALU_SUB;
      end
      LUI, AUIPC: begin
        dec_o.rd       = inst_i[11:7];
        dec_o.imm      = imm_u;
        dec_o.alu_ctrl = ALU_ADD;
        wr             = 1'b1;
      end
      JAL: begin
        dec_o.rd       = inst_i[11:7];
        dec_o.imm      = imm_j;
        dec_o.alu_ctrl = ALU_ADD;
        wr             = 1'b1;
      end
      JALR: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rd       = inst_i[11:7];
        dec_o.imm      = imm_i;
        dec_o.alu_ctrl = ALU_ADD;
        wr             = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (inst_i[1:0] != 2'b11) ill = 1'b1;
    dec_o.illegal = ill;
    dec_o.w_en    = wr && !ill && (dec_o.rd != 5'd0);
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered decode stage: combinational decode into an output FIFO.
// Optional RV32M decode via DECODE_RV32M_EN (see rv32_decode_comb).
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_ctrl,
  output logic            w_en,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            muldiv
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dec_t dec;

  rv32_decode_comb u_comb (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  dec_t            ent_q [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop;

  // Readiness depends only on stored occupancy, never on out_ready
  assign in_ready  = !rst && (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointer and occupancy next-state; flush wins over push/pop
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO state and storage, cleared on reset so outputs read zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) begin
        ent_q[wr_q] <= dec;
        pc_q[wr_q]  <= in_pc;
      end
    end
  end

  assign out_pc   = pc_q[rd_q];
  assign rs1      = ent_q[rd_q].rs1;
  assign rs2      = ent_q[rd_q].rs2;
  assign rd       = ent_q[rd_q].rd;
  assign alu_ctrl = ent_q[rd_q].alu_ctrl;
  assign w_en     = ent_q[rd_q].w_en;
  assign imm      = ent_q[rd_q].imm;
  assign illegal  = ent_q[rd_q].illegal;
  assign muldiv   = ent_q[rd_q].muldiv;

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Registered, flow-controlled RV32I instruction decode stage: accepts fetched instructions with their PC over a valid/ready handshake, decodes register indices, ALU control, write enable and immediate, and delivers them through a parametrised output FIFO. It sits between fetch and execute. It adds buffering, back-pressure, flush, an illegal-instruction flag and optional RV32M decode to the existing purely combinational decoder.

## Interface
Parameters:
- XLEN, 32 — width of pc and imm; only 32 is legal.
- DEPTH, 2 — output FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- flush  in  1  discard all buffered entries and the same-cycle input beat
- in_valid  in  1  instruction beat valid
- in_ready  out  1  stage can accept a beat
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  consumer accepts entry
- out_pc  out  XLEN  PC of the entry
- rs1, rs2, rd  out  5 each  register indices
- alu_ctrl  out  4  ALU operation
- w_en  out  1  register write enable
- imm  out  XLEN  sign-extended immediate
- illegal  out  1  unsupported or malformed encoding
- muldiv  out  1  RV32M operation (0 when RV32M is compiled out)

## Operation
- Decode is combinational on in_inst. The result and in_pc are written into the FIFO on push (in_valid && in_ready && !flush).
- Pop on out_valid && out_ready. out_* always present the FIFO head.
- alu_ctrl = {funct7[5], funct3} for OP. For OP-IMM it is the same, but bit 3 is forced to 0 except SRAI. LOAD, STORE, LUI, AUIPC, JAL and JALR use ADD (0000). Branches use SUB (1000).
- imm by format:
  - I, S, B, U and J types use standard RV32 sign-extended assembly.
  - U-type places imm[31:12] with low bits zero.
  - R-type imm = 0.
- rs2 = inst[24:20] for R, S and B types, else 0. rs1 = 0 for U and J types.
- w_en = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, and only when rd ≠ 0.
- illegal = 1 in these cases:
  - unknown opcode;
  - OP with funct7 ∉ {0000000, 0100000}, or with 0100000 on funct3 ∉ {000, 101};
  - shift-immediate with a bad funct7;
  - inst[1:0] ≠ 11.
- Illegal entries are still enqueued, with w_en = 0.

## Timing
- Reset: FIFO empty; out_valid = 0; all out_* data = 0; illegal = 0; muldiv = 0; in_ready = 0 while rst is high, 1 from the first cycle after deassertion.
- Latency: a beat accepted at edge N into an empty FIFO gives out_valid = 1 after edge N.
- in_ready = (count < DEPTH). It is registered state only, with no combinational path from out_ready. When full, a same-cycle pop does not allow a push.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- flush: at the next edge count = 0 and out_valid = 0. A push or pop in the same cycle is ignored. flush during reset has no effect.
- Reset asserted mid-operation clears the FIFO immediately, whatever out_ready is.

## Configuration
- DECODE_RV32M_EN defined: OP with funct7 = 0000001 decodes with muldiv = 1, alu_ctrl = {0, funct3}, w_en per rd, illegal = 0.
- Not defined: that encoding sets illegal = 1 and w_en = 0. muldiv is tied to 0.

## Structure
- Package rv32_decode_pkg holds:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR;
  - alu_ctrl constants: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111;
  - the decoded-entry struct.
- Sub-module rv32_decode_comb holds the pure combinational decoder. rv32_decode_stage holds the FIFO and handshake.

## Test plan
- addi x1,x0,5 (0x00500093) after reset → one cycle later out_valid = 1, rs1 = 0, rd = 1, imm = 0x00000005, alu_ctrl = 0000, w_en = 1, illegal = 0.
- sub x3,x1,x2 (0x402081B3), then sw x2,8(x1) (0x0020A423) → in order: alu_ctrl = 1000, rd = 3, w_en = 1; then imm = 8, rs1 = 1, rs2 = 2, w_en = 0.
- out_ready = 0 while pushing lui x5,0x12345 (0x123452B7) DEPTH times → in_ready = 0 after DEPTH accepts. The head shows imm = 0x12345000. Releasing out_ready drains the entries in order.
- Two entries buffered, flush = 1 with in_valid = 1 → next cycle out_valid = 0 and the new beat is discarded.
- mul x3,x1,x2 (0x022081B3) → with DECODE_RV32M_EN: muldiv = 1, alu_ctrl = 0000, illegal = 0. Without it: illegal = 1, w_en = 0.
- 0xFFFFFFFF and addi x0,x0,0 (0x00000013) → the first gives illegal = 1; the second gives w_en = 0 with illegal = 0.
